mont_entry_conv: RTL and testbench



---
 rtl/paillier_pkg.sv | 43 ++++
 rtl/mont_entry_conv_if.sv | 28 ++
 rtl/mont_entry_conv_montcios.sv | 81 ++++++++
 rtl/mont_entry_conv.sv | 149 ++++++++++++++
 tb/tb_mont_entry_conv.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/paillier_pkg.sv
// Shared Paillier front-end definitions: FSM state encoding, a limb-array
// type for the default operand size, and the MSB-limb-first magnitude compare
// used by the optional operand range check (MONT_ENTRY_RANGE_CHECK_EN).
package paillier_pkg;

    localparam int PKG_WIDTH = 32;
    localparam int PKG_S     = 8;

    // Operand as S limbs of WIDTH bits, limb 0 least significant
    typedef logic [PKG_S-1:0][PKG_WIDTH-1:0] limb_arr_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_G,
        WAIT_G,
        ISSUE_R,
        WAIT_R,
        ISSUE_ONE,
        WAIT_ONE,
        FIN
    } state_e;

    // limb_ge works on zero-extended operands of up to GE_LIMBS*GE_LIMB_W bits
    localparam int GE_LIMB_W = 32;
    localparam int GE_LIMBS  = 32;
    typedef logic [GE_LIMBS*GE_LIMB_W-1:0] ge_vec_t;

    // Unsigned a >= b, deciding on the most significant differing limb
    function automatic logic limb_ge(input ge_vec_t a, input ge_vec_t b);
        logic decided;
        logic ge;
        decided = 1'b0;
        ge      = 1'b1;
        for (int i = GE_LIMBS - 1; i >= 0; i--) begin
            if (!decided && (a[i*GE_LIMB_W +: GE_LIMB_W] != b[i*GE_LIMB_W +: GE_LIMB_W])) begin
                ge      = (a[i*GE_LIMB_W +: GE_LIMB_W] > b[i*GE_LIMB_W +: GE_LIMB_W]);
                decided = 1'b1;
            end
        end
        return ge;
    endfunction

endpackage

// File: rtl/mont_entry_conv_if.sv
// Request/result bundle between the Paillier front-end and its user.
interface mont_entry_conv_if #(
    parameter int WIDTH = 32,
    parameter int S     = 8
);
    logic                    start;
    logic [S-1:0][WIDTH-1:0] g;
    logic [S-1:0][WIDTH-1:0] r;
    logic [S-1:0][WIDTH-1:0] n;
    logic [S-1:0][WIDTH-1:0] r2;
    logic [WIDTH-1:0]        p_prime;
    logic [S-1:0][WIDTH-1:0] g_mont;
    logic [S-1:0][WIDTH-1:0] r_mont;
    logic [S-1:0][WIDTH-1:0] mont_one;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        output start, g, r, n, r2, p_prime,
        input  g_mont, r_mont, mont_one, busy, done, err
    );

    modport slave (
        input  start, g, r, n, r2, p_prime,
        output g_mont, r_mont, mont_one, busy, done, err
    );
endinterface

// File: rtl/mont_entry_conv_montcios.sv
// Iterative Montgomery multiplier: tout = a*b*R^-1 mod p, R = 2^(S*WIDTH),
// fully reduced. One limb of a is consumed per cycle, then one cycle of final
// subtraction, then N cycles of done delay. Latency from start to done is
// S+N+1 cycles (N >= 1). A start while running restarts the operation.
module montcios #(
    parameter int WIDTH = 32,
    parameter int S     = 8,
    parameter int N     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [S-1:0][WIDTH-1:0] a,
    input  logic [S-1:0][WIDTH-1:0] b,
    input  logic [S-1:0][WIDTH-1:0] p,
    input  logic [WIDTH-1:0]        p_prime,
    output logic [S-1:0][WIDTH-1:0] tout,
    output logic                    done
);
    localparam int BITS  = WIDTH * S;
    localparam int TBITS = BITS + 1;          // running T stays below 2p
    localparam int TW    = BITS + WIDTH + 1;  // T + a_i*b + m*p < 2^(W+1)*p
    localparam int CW    = $clog2(S + 1);

    logic [S-1:0][WIDTH-1:0] a_sh_reg, b_reg, p_reg, tout_reg;
    logic [WIDTH-1:0]        pp_reg;
    logic [BITS:0]           t_reg;
    logic [CW-1:0]           cnt_reg;
    logic                    run_reg;
    logic [N-1:0]            done_pipe_reg;

    logic [TW-1:0]    sum1, sum2;
    logic [WIDTH-1:0] m;
    logic [BITS:0]    t_iter, t_sub;
    logic             fin;

    assign sum1   = TW'(t_reg) + TW'(a_sh_reg[0]) * TW'(b_reg);
    assign m      = WIDTH'(sum1[WIDTH-1:0] * pp_reg);
    assign sum2   = sum1 + TW'(m) * TW'(p_reg);
    assign t_iter = TBITS'(sum2 >> WIDTH);
    assign t_sub  = t_reg - {1'b0, p_reg};
    assign fin    = run_reg && (cnt_reg == CW'(S)) && !start;

    // Limb iteration, final conditional subtract and done delay line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_reg      <= '0;
            b_reg         <= '0;
            p_reg         <= '0;
            pp_reg        <= '0;
            t_reg         <= '0;
            cnt_reg       <= '0;
            run_reg       <= 1'b0;
            tout_reg      <= '0;
            done_pipe_reg <= '0;
        end else begin
            done_pipe_reg <= N'({done_pipe_reg, fin});
            if (start) begin
                a_sh_reg <= a;
                b_reg    <= b;
                p_reg    <= p;
                pp_reg   <= p_prime;
                t_reg    <= '0;
                cnt_reg  <= '0;
                run_reg  <= 1'b1;
            end else if (run_reg) begin
                if (cnt_reg == CW'(S)) begin
                    tout_reg <= (t_reg >= {1'b0, p_reg}) ? BITS'(t_sub) : BITS'(t_reg);
                    run_reg  <= 1'b0;
                end else begin
                    t_reg    <= t_iter;
                    a_sh_reg <= a_sh_reg >> WIDTH;
                    cnt_reg  <= cnt_reg + CW'(1);
                end
            end
        end
    end

    assign tout = tout_reg;
    assign done = done_pipe_reg[N-1];
endmodule

// File: rtl/mont_entry_conv.sv
// Paillier front-end: converts g, r and 1 into Montgomery form by multiplying
// each by R^2 mod n through one shared montcios, then pulses done, which also
// serves as the encrypt-stage start.
// Optional build macro MONT_ENTRY_RANGE_CHECK_EN: rejects g >= n or r >= n
// with err, skipping all multiplications.
module mont_entry_conv
    import paillier_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int S     = 8,
    parameter int N     = 3
) (
    input  logic             clk,
    input  logic             rst,
    mont_entry_conv_if.slave bus
);
    localparam int BITS = WIDTH * S;

    localparam logic [2:0] ST_IDLE      = IDLE;
    localparam logic [2:0] ST_ISSUE_G   = ISSUE_G;
    localparam logic [2:0] ST_WAIT_G    = WAIT_G;
    localparam logic [2:0] ST_ISSUE_R   = ISSUE_R;
    localparam logic [2:0] ST_WAIT_R    = WAIT_R;
    localparam logic [2:0] ST_ISSUE_ONE = ISSUE_ONE;
    localparam logic [2:0] ST_WAIT_ONE  = WAIT_ONE;
    localparam logic [2:0] ST_FIN       = FIN;

    typedef logic [S-1:0][WIDTH-1:0] limbs_t;

    logic [2:0]       state_reg, state_next;
    limbs_t           g_q_reg, r_q_reg, n_q_reg, r2_q_reg;
    logic [WIDTH-1:0] pp_q_reg;
    limbs_t           g_mont_reg, r_mont_reg, one_mont_reg;
    limbs_t           tout_q_reg, mont_tout, mont_a, one_val;
    logic             done_q_reg, mont_done, mont_start, range_err;

    assign one_val = BITS'(1);

`ifdef MONT_ENTRY_RANGE_CHECK_EN
    localparam int GE_BITS = GE_LIMBS * GE_LIMB_W;
    ge_vec_t g_wide, r_wide, n_wide;
    logic    err_reg;

    assign g_wide    = {{(GE_BITS-BITS){1'b0}}, g_q_reg};
    assign r_wide    = {{(GE_BITS-BITS){1'b0}}, r_q_reg};
    assign n_wide    = {{(GE_BITS-BITS){1'b0}}, n_q_reg};
    assign range_err = (state_reg == ST_ISSUE_G) && (limb_ge(g_wide, n_wide) || limb_ge(r_wide, n_wide));

    // err sets on a rejected request and clears on the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && bus.start) begin
            err_reg <= 1'b0;
        end else if (range_err) begin
            err_reg <= 1'b1;
        end
    end

    assign bus.err = err_reg;
`else
    assign range_err = 1'b0;
    assign bus.err   = 1'b0;
`endif

    // Operand a follows the phase; b and p are fixed for the whole request
    always_comb begin
        mont_a = g_q_reg;
        case (state_reg)
            ST_ISSUE_R, ST_WAIT_R:     mont_a = r_q_reg;
            ST_ISSUE_ONE, ST_WAIT_ONE: mont_a = one_val;
            default:                   mont_a = g_q_reg;
        endcase
    end

    assign mont_start = ((state_reg == ST_ISSUE_G) && !range_err)
                      || (state_reg == ST_ISSUE_R)
                      || (state_reg == ST_ISSUE_ONE);

    // Sequencer: three issue/wait phases, then a one-cycle FIN
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (bus.start) state_next = ST_ISSUE_G;
            ST_ISSUE_G:   state_next = range_err ? ST_FIN : ST_WAIT_G;
            ST_WAIT_G:    if (done_q_reg) state_next = ST_ISSUE_R;
            ST_ISSUE_R:   state_next = ST_WAIT_R;
            ST_WAIT_R:    if (done_q_reg) state_next = ST_ISSUE_ONE;
            ST_ISSUE_ONE: state_next = ST_WAIT_ONE;
            ST_WAIT_ONE:  if (done_q_reg) state_next = ST_FIN;
            ST_FIN:       state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // State, operand latch and result capture; montcios done/result are
    // registered once to keep the wide result path off the FSM timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            g_q_reg      <= '0;
            r_q_reg      <= '0;
            n_q_reg      <= '0;
            r2_q_reg     <= '0;
            pp_q_reg     <= '0;
            g_mont_reg   <= '0;
            r_mont_reg   <= '0;
            one_mont_reg <= '0;
            tout_q_reg   <= '0;
            done_q_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            done_q_reg <= mont_done;
            tout_q_reg <= mont_tout;
            if (state_reg == ST_IDLE && bus.start) begin
                g_q_reg  <= bus.g;
                r_q_reg  <= bus.r;
                n_q_reg  <= bus.n;
                r2_q_reg <= bus.r2;
                pp_q_reg <= bus.p_prime;
            end
            if (state_reg == ST_WAIT_G && done_q_reg)   g_mont_reg   <= tout_q_reg;
            if (state_reg == ST_WAIT_R && done_q_reg)   r_mont_reg   <= tout_q_reg;
            if (state_reg == ST_WAIT_ONE && done_q_reg) one_mont_reg <= tout_q_reg;
        end
    end

    montcios #(
        .WIDTH (WIDTH),
        .S     (S),
        .N     (N)
    ) u_montcios (
        .clk     (clk),
        .rst     (rst),
        .start   (mont_start),
        .a       (mont_a),
        .b       (r2_q_reg),
        .p       (n_q_reg),
        .p_prime (pp_q_reg),
        .tout    (mont_tout),
        .done    (mont_done)
    );

    assign bus.g_mont   = g_mont_reg;
    assign bus.r_mont   = r_mont_reg;
    assign bus.mont_one = one_mont_reg;
    assign bus.busy     = (state_reg != ST_IDLE) && (state_reg != ST_FIN);
    assign bus.done     = (state_reg == ST_FIN);
endmodule

// File: tb/tb_mont_entry_conv.sv
// Bench for mont_entry_conv with WIDTH=4, S=2, n=0xB7, R=256, R mod n=0x49.
module tb_mont_entry_conv;
    localparam int WIDTH = 4;
    localparam int S     = 2;
    localparam int N     = 3;
    localparam int LM    = S + N + 1;           // montcios start-to-done
    localparam int LAT   = 3 * (LM + 2) + 1;    // start cycle to done cycle

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   mont_starts = 0;

    mont_entry_conv_if #(.WIDTH(WIDTH), .S(S)) bus ();

    mont_entry_conv #(.WIDTH(WIDTH), .S(S), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] g_mont;
        logic [7:0] r_mont;
        logic [7:0] one;
        logic       err;
        int         start_cyc;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] e_g;
        logic [7:0] e_r;
    } vec_t;

    exp_t sb_q[$];
    exp_t e;
    logic [7:0] last_g = 8'h00;
    logic [7:0] last_r = 8'h00;
    logic [7:0] last_one = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: compare each done pulse against the oldest request
    always @(negedge clk) begin
        if (!rst) begin
            if (dut.mont_start) mont_starts++;
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("g_mont", 32'(bus.g_mont), 32'(e.g_mont));
                    check("r_mont", 32'(bus.r_mont), 32'(e.r_mont));
                    check("mont_one", 32'(bus.mont_one), 32'(e.one));
                    check("err", 32'(bus.err), 32'(e.err));
                    check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                    check("busy_at_done", 32'(bus.busy), 32'd0);
                    $display("txn start_cyc=%0d done_cyc=%0d g_mont=%02h r_mont=%02h mont_one=%02h err=%0b",
                             e.start_cyc, cyc, bus.g_mont, bus.r_mont, bus.mont_one, bus.err);
                    last_g   = e.g_mont;
                    last_r   = e.r_mont;
                    last_one = e.one;
                end
            end else if (sb_q.size() != 0 && cyc > sb_q[0].start_cyc &&
                         cyc < sb_q[0].start_cyc + sb_q[0].lat) begin
                check("busy", 32'(bus.busy), 32'd1);
            end
        end
    end

    task automatic do_start(input logic [7:0] g, input logic [7:0] r,
                            input logic [7:0] eg, input logic [7:0] er, input logic [7:0] eone,
                            input logic eerr, input int lat, output int sc);
        exp_t x;
        @(negedge clk);
        bus.g       = g;
        bus.r       = r;
        bus.n       = 8'hB7;
        bus.r2      = 8'h16;
        bus.p_prime = 4'h9;
        bus.start   = 1'b1;
        sc          = cyc;
        x.g_mont = eg; x.r_mont = er; x.one = eone; x.err = eerr; x.start_cyc = sc; x.lat = lat;
        sb_q.push_back(x);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.g       = 8'($urandom);
        bus.r       = 8'($urandom);
        bus.n       = 8'($urandom);
        bus.r2      = 8'($urandom);
        bus.p_prime = 4'($urandom);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: got %0d pending results expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    vec_t vecs[6];
    int   s;
    int   ms0;

    initial begin
        vecs[0] = '{8'h02, 8'h05, 8'h92, 8'hB6};
        vecs[1] = '{8'h01, 8'hB6, 8'h49, 8'h6E};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{8'hB6, 8'h01, 8'h6E, 8'h49};
        vecs[4] = '{8'h10, 8'h7F, 8'h46, 8'h79};
        vecs[5] = '{8'hAA, 8'h55, 8'h95, 8'hA6};

        bus.start = 1'b0; bus.g = '0; bus.r = '0;
        bus.n = 8'hB7; bus.r2 = 8'h16; bus.p_prime = 4'h9;
        repeat (3) @(negedge clk);
        check("rst_g_mont", 32'(bus.g_mont), 32'd0);
        check("rst_r_mont", 32'(bus.r_mont), 32'd0);
        check("rst_mont_one", 32'(bus.mont_one), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;

        // Table: back-to-back conversions, each started the cycle after done
        for (int i = 0; i < 6; i++) begin
            do_start(vecs[i].g, vecs[i].r, vecs[i].e_g, vecs[i].e_r, 8'h49, 1'b0, LAT, s);
            wait_drain(LAT + 10);
        end

        // Outputs of the previous run hold until each is recaptured
        do_start(8'h02, 8'h05, 8'h92, 8'hB6, 8'h49, 1'b0, LAT, s);
        while (cyc < s + 4) @(negedge clk);
        check("hold_g_mont", 32'(bus.g_mont), 32'h95);
        while (cyc < s + 12) @(negedge clk);
        check("new_g_mont", 32'(bus.g_mont), 32'h92);
        check("hold_r_mont", 32'(bus.r_mont), 32'hA6);
        wait_drain(LAT + 10);

        // start during FIN is dropped
        bus.g = 8'h10; bus.r = 8'h10; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("fin_start_busy", 32'(bus.busy), 32'd0);
        repeat (LAT + 3) @(negedge clk);
        check("fin_start_g_mont", 32'(bus.g_mont), 32'h92);

        // start while busy (WAIT_R) is dropped
        do_start(8'h01, 8'hB6, 8'h49, 8'h6E, 8'h49, 1'b0, LAT, s);
        while (cyc < s + 11) @(negedge clk);
        bus.g = 8'h10; bus.r = 8'h10; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain(LAT + 10);
        repeat (LAT + 3) @(negedge clk);

        // Asynchronous reset during WAIT_G
        do_start(8'hAA, 8'h55, 8'h95, 8'hA6, 8'h49, 1'b0, LAT, s);
        while (cyc < s + 4) @(negedge clk);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_err", 32'(bus.err), 32'd0);
        check("arst_g_mont", 32'(bus.g_mont), 32'd0);
        check("arst_r_mont", 32'(bus.r_mont), 32'd0);
        check("arst_mont_one", 32'(bus.mont_one), 32'd0);
        last_g = 8'h00; last_r = 8'h00; last_one = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        do_start(8'h10, 8'h7F, 8'h46, 8'h79, 8'h49, 1'b0, LAT, s);
        wait_drain(LAT + 10);

        // g equal to n
        ms0 = mont_starts;
`ifdef MONT_ENTRY_RANGE_CHECK_EN
        do_start(8'hB7, 8'h05, last_g, last_r, last_one, 1'b1, 2, s);
        wait_drain(LAT + 10);
        check("range_mont_starts", 32'(mont_starts - ms0), 32'd0);
        @(negedge clk);
        check("range_err_hold", 32'(bus.err), 32'd1);
`else
        do_start(8'hB7, 8'h05, 8'h00, 8'hB6, 8'h49, 1'b0, LAT, s);
        wait_drain(LAT + 10);
        check("range_mont_starts", 32'(mont_starts - ms0), 32'd3);
`endif
        do_start(8'h02, 8'h05, 8'h92, 8'hB6, 8'h49, 1'b0, LAT, s);
        wait_drain(LAT + 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within 200000 time units");
        $fatal(1, "watchdog");
    end
endmodule
